// File: rtl/hdmi_tx_stream.sv
// 640x480 raster timing generator and pixel streamer feeding the TMDS encoder.
// Optional colour-bar generator: define HDMI_TX_TESTPATTERN_EN.
module hdmi_tx_stream #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        test_mode,
    output logic [11:0] xaddr,
    output logic [11:0] yaddr,
    output logic        rd_en,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic        valid,
    output logic [1:0]  sync,
    output logic [7:0]  d0,
    output logic [7:0]  d1,
    output logic [7:0]  d2,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        active;
    logic        hs_n;
    logic        vs_n;
    logic        first;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? 12'd0 : vcount + 12'd1;
        end else begin
            hcount <= hcount + 12'd1;
        end
    end

    assign active = (hcount < H_ACT) && (vcount < V_ACT);
    assign hs_n   = ~((hcount >= HS_BEG) && (hcount < HS_END));
    assign vs_n   = ~((vcount >= VS_BEG) && (vcount < VS_END));
    assign first  = (hcount == 12'd0) && (vcount == 12'd0);

    assign rd_en = active & ~reset;
    assign xaddr = rd_en ? hcount : 12'd0;
    assign yaddr = rd_en ? vcount : 12'd0;

    // Flags ride alongside the framebuffer read so they meet r/g/b.
    logic       act_sr [READ_LATENCY];
    logic [1:0] syn_sr [READ_LATENCY];
    logic       fst_sr [READ_LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                act_sr[i] <= 1'b0;
                syn_sr[i] <= 2'b11;
                fst_sr[i] <= 1'b0;
            end
        end else begin
            act_sr[0] <= rd_en;
            syn_sr[0] <= {vs_n, hs_n};
            fst_sr[0] <= first;
            for (int i = 1; i < READ_LATENCY; i++) begin
                act_sr[i] <= act_sr[i-1];
                syn_sr[i] <= syn_sr[i-1];
                fst_sr[i] <= fst_sr[i-1];
            end
        end
    end

    logic [7:0] pr;
    logic [7:0] pg;
    logic [7:0] pb;

`ifdef HDMI_TX_TESTPATTERN_EN
    localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);

    logic [11:0] dx_sr [READ_LATENCY];
    logic [2:0]  bar;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) dx_sr[i] <= '0;
        end else begin
            dx_sr[0] <= xaddr;
            for (int i = 1; i < READ_LATENCY; i++) dx_sr[i] <= dx_sr[i-1];
        end
    end

    assign bar = 3'(dx_sr[READ_LATENCY-1] / BAR_W);

    // Bar index bits select the primaries: white..black in 75% bar order.
    always_comb begin
        pr = r;
        pg = g;
        pb = b;
        if (test_mode) begin
            pr = {8{~bar[1]}};
            pg = {8{~bar[2]}};
            pb = {8{~bar[0]}};
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;

    always_comb begin
        pr = r;
        pg = g;
        pb = b;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid       <= 1'b0;
            sync        <= 2'b11;
            d0          <= '0;
            d1          <= '0;
            d2          <= '0;
            frame_start <= 1'b0;
        end else begin
            valid       <= act_sr[READ_LATENCY-1];
            sync        <= syn_sr[READ_LATENCY-1];
            d2          <= act_sr[READ_LATENCY-1] ? pr : 8'd0;
            d1          <= act_sr[READ_LATENCY-1] ? pg : 8'd0;
            d0          <= act_sr[READ_LATENCY-1] ? pb : 8'd0;
            frame_start <= fst_sr[READ_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_hdmi_tx_stream.sv
// Scoreboard bench for hdmi_tx_stream on a shrunk raster with random pixels.
// Expected outputs come from raster position arithmetic, not from the RTL.
module tb_hdmi_tx_stream;

    localparam int HA  = 64;
    localparam int HFP = 4;
    localparam int HS  = 8;
    localparam int HBP = 4;
    localparam int VA  = 16;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int RL  = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FR  = HT * VT;

`ifdef HDMI_TX_TESTPATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        test_mode = 1'b0;
    logic [11:0] xaddr;
    logic [11:0] yaddr;
    logic        rd_en;
    logic [7:0]  r = 8'd0;
    logic [7:0]  g = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        valid;
    logic [1:0]  sync;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic        frame_start;

    hdmi_tx_stream #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .test_mode(test_mode),
        .xaddr(xaddr),
        .yaddr(yaddr),
        .rd_en(rd_en),
        .r(r),
        .g(g),
        .b(b),
        .valid(valid),
        .sync(sync),
        .d0(d0),
        .d1(d1),
        .d2(d2),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd_en;
        logic [11:0] xa;
        logic [11:0] ya;
        logic        valid;
        logic [1:0]  sync;
        logic [23:0] pix;
        logic        fs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    logic [23:0] p_rgb;
    logic        p_tm;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    endtask

    function automatic void geom(input int c, output int x, output int y,
                                 output bit act, output bit hs,
                                 output bit vs, output bit fs);
        int p;
        p   = c % FR;
        x   = p % HT;
        y   = p / HT;
        act = (x < HA) && (y < VA);
        hs  = !((x >= HA + HFP) && (x < HA + HFP + HS));
        vs  = !((y >= VA + VFP) && (y < VA + VFP + VS));
        fs  = (p == 0);
    endfunction

    function automatic logic [23:0] bar_rgb(input int x);
        case (x / (HA / 8))
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic drive(input bit rst);
        exp_t e;
        int   x, y, k;
        bit   act, hs, vs, fs;
        @(posedge clk);
        #1;
        reset = rst;
        p_rgb = {r, g, b};
        p_tm  = test_mode;
        r = 8'($urandom);
        g = 8'($urandom);
        b = 8'($urandom);
        if ($urandom_range(0, 150) == 0) test_mode = ~test_mode;
        if (rst) begin
            e.rd_en = 1'b0;
            e.xa    = '0;
            e.ya    = '0;
            e.valid = 1'b0;
            e.sync  = 2'b11;
            e.pix   = '0;
            e.fs    = 1'b0;
            cyc = 0;
        end else begin
            geom(cyc, x, y, act, hs, vs, fs);
            e.rd_en = act;
            e.xa    = act ? 12'(x) : 12'd0;
            e.ya    = act ? 12'(y) : 12'd0;
            k = cyc - RL - 1;
            if (k < 0) begin
                e.valid = 1'b0;
                e.sync  = 2'b11;
                e.pix   = '0;
                e.fs    = 1'b0;
            end else begin
                geom(k, x, y, act, hs, vs, fs);
                e.valid = act;
                e.sync  = {vs, hs};
                e.fs    = fs;
                if (!act) e.pix = '0;
                else if (TP && p_tm) e.pix = bar_rgb(x);
                else e.pix = p_rgb;
            end
            cyc++;
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("stage0", 64'({rd_en, xaddr, yaddr}),
                  64'({e.rd_en, e.xa, e.ya}));
            check("outputs", 64'({valid, sync, d2, d1, d0, frame_start}),
                  64'({e.valid, e.sync, e.pix, e.fs}));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (5) drive(1'b1);
        repeat (2 * FR + $urandom_range(100, 900)) drive(1'b0);
        repeat (5) drive(1'b1);
        repeat (2 * FR + 20) drive(1'b0);
        @(negedge clk);
        #1;
        check("queue_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
